// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
//   Shared configuration and types for the Tomasulo reorder buffer (RB).
//   WORD_SIZE : data word width
//   RB_SIZE   : number of entries (must satisfy RB_SIZE <= 2**RB_INDEX-1)
//   RB_INDEX  : tag width; the all-ones tag is NULL/READY and never allocated
//   FU_NUM    : number of functional-unit writeback lanes
//   REG_INDEX : architectural register index width
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int WORD_SIZE = 16;
  localparam int RB_SIZE   = 7;
  localparam int RB_INDEX  = 3;
  localparam int FU_NUM    = 4;
  localparam int REG_INDEX = 3;

  localparam logic [RB_INDEX-1:0] RB_NULL_TAG = '1;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 is_branch;
    logic [REG_INDEX-1:0] dest_reg;
    logic [WORD_SIZE-1:0] value;
  } rb_entry_t;

  // Circular pointer increment, wrapping RB_SIZE-1 -> 0.
  function automatic logic [RB_INDEX-1:0] rb_next(input logic [RB_INDEX-1:0] p);
    return (p == RB_INDEX'(RB_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
//   Bundles the RB's issue, writeback, CDB broadcast and commit signals.
//   master : issue stage / FUs / RSs / register file side
//   slave  : the reorder buffer
//   Issue  : alloc_req, alloc_dest_reg, alloc_is_branch -> alloc_ready, alloc_index
//   FU WB  : data_bus, valid_bus, RB_index_bus (lane f at [f*W +: W])
//   CDB    : CDB_data_data, CDB_data_valid (entry i at [i*WORD_SIZE +: WORD_SIZE])
//   Commit : commit_valid, commit_reg, commit_data, commit_index, flush, reset_bus
// -----------------------------------------------------------------------------
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
  ();

  logic                          alloc_req;
  logic [REG_INDEX-1:0]          alloc_dest_reg;
  logic                          alloc_is_branch;
  logic                          alloc_ready;
  logic [RB_INDEX-1:0]           alloc_index;
  logic [FU_NUM*WORD_SIZE-1:0]   data_bus;
  logic [FU_NUM-1:0]             valid_bus;
  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus;
  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data;
  logic [RB_SIZE-1:0]            CDB_data_valid;
  logic                          commit_valid;
  logic [REG_INDEX-1:0]          commit_reg;
  logic [WORD_SIZE-1:0]          commit_data;
  logic [RB_INDEX-1:0]           commit_index;
  logic                          flush;
  logic [FU_NUM-1:0]             reset_bus;

  modport master (
    output alloc_req, alloc_dest_reg, alloc_is_branch,
    output data_bus, valid_bus, RB_index_bus,
    input  alloc_ready, alloc_index,
    input  CDB_data_data, CDB_data_valid,
    input  commit_valid, commit_reg, commit_data, commit_index, flush, reset_bus
  );

  modport slave (
    input  alloc_req, alloc_dest_reg, alloc_is_branch,
    input  data_bus, valid_bus, RB_index_bus,
    output alloc_ready, alloc_index,
    output CDB_data_data, CDB_data_valid,
    output commit_valid, commit_reg, commit_data, commit_index, flush, reset_bus
  );

endinterface

// File: rtl/reorder_buffer_rb_wb_match.sv
// -----------------------------------------------------------------------------
// rb_wb_match
//   Combinational writeback lane matcher for one RB entry (tag IDX).
//   Reports whether any valid FU lane targets this entry and returns the data
//   of the lowest-numbered matching lane.
//   Ports: data_bus, valid_bus, RB_index_bus (in); hit, data (out)
// -----------------------------------------------------------------------------
module rb_wb_match
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic [FU_NUM*WORD_SIZE-1:0] data_bus,
  input  logic [FU_NUM-1:0]           valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]  RB_index_bus,
  output logic                        hit,
  output logic [WORD_SIZE-1:0]        data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned f = 0; f < FU_NUM; f++) begin
      if (!hit && valid_bus[f] &&
          RB_index_bus[f*RB_INDEX +: RB_INDEX] != RB_NULL_TAG &&
          RB_index_bus[f*RB_INDEX +: RB_INDEX] == RB_INDEX'(IDX)) begin
        hit  = 1'b1;
        data = data_bus[f*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order reorder buffer for the Tomasulo core. Hands out tags at
//   issue, captures FU results, broadcasts completed values on the CDB, commits
//   the head entry in order, and flushes everything on a taken-branch commit.
//   Ports: clk, reset_n (async active-low), rb (reorder_buffer_if.slave)
//   Build option: RB_BYPASS_EN -- when defined, the CDB outputs also show this
//   cycle's accepted writebacks combinationally; otherwise they are registered.
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  reorder_buffer_if.slave rb
);

  rb_entry_t            ent_q [RB_SIZE];
  rb_entry_t            ent_d [RB_SIZE];
  logic [RB_INDEX-1:0]  head_q, head_d;
  logic [RB_INDEX-1:0]  tail_q, tail_d;
  logic [RB_INDEX-1:0]  count_q, count_d;
  logic                 flush_q, flush_d;
  logic                 cvalid_q, cvalid_d;
  logic [REG_INDEX-1:0] creg_q, creg_d;
  logic [WORD_SIZE-1:0] cdata_q, cdata_d;
  logic [RB_INDEX-1:0]  cidx_q, cidx_d;

  logic [RB_SIZE-1:0]   wb_hit;
  logic [RB_SIZE-1:0]   wb_acc;
  logic [WORD_SIZE-1:0] wb_data [RB_SIZE];

  logic alloc_ready;
  logic alloc_fire;
  logic commit_fire;
  logic taken;

  for (genvar i = 0; i < RB_SIZE; i++) begin : g_match
    rb_wb_match #(.IDX(i)) u_match (
      .data_bus     (rb.data_bus),
      .valid_bus    (rb.valid_bus),
      .RB_index_bus (rb.RB_index_bus),
      .hit          (wb_hit[i]),
      .data         (wb_data[i])
    );
    // Only busy, not-yet-done entries accept results; nothing is accepted in
    // the flush cycle.
    assign wb_acc[i] = wb_hit[i] & ent_q[i].busy & ~ent_q[i].done & ~flush_q;
  end

  // Ready depends on registered state only: a commit in the same cycle does
  // not free a slot for an alloc at that edge.
  assign alloc_ready = (count_q != RB_INDEX'(RB_SIZE)) & ~flush_q;
  assign alloc_fire  = rb.alloc_req & alloc_ready;
  assign commit_fire = ent_q[head_q].busy & ent_q[head_q].done;
  assign taken       = commit_fire & ent_q[head_q].is_branch & ent_q[head_q].value[0];

  always_comb begin
    ent_d    = ent_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q + RB_INDEX'(alloc_fire) - RB_INDEX'(commit_fire);
    flush_d  = taken;
    cvalid_d = 1'b0;
    creg_d   = '0;
    cdata_d  = '0;
    cidx_d   = '0;

    for (int unsigned i = 0; i < RB_SIZE; i++) begin
      if (wb_acc[i]) begin
        ent_d[i].done  = 1'b1;
        ent_d[i].value = wb_data[i];
      end
    end

    if (commit_fire) begin
      cvalid_d      = ~ent_q[head_q].is_branch;
      creg_d        = ent_q[head_q].dest_reg;
      cdata_d       = ent_q[head_q].value;
      cidx_d        = head_q;
      ent_d[head_q] = '0;
      head_d        = rb_next(head_q);
    end

    if (alloc_fire) begin
      ent_d[tail_q].busy      = 1'b1;
      ent_d[tail_q].done      = 1'b0;
      ent_d[tail_q].is_branch = rb.alloc_is_branch;
      ent_d[tail_q].dest_reg  = rb.alloc_dest_reg;
      ent_d[tail_q].value     = '0;
      tail_d                  = rb_next(tail_q);
    end

    // Taken branch overrides everything at this edge, including an alloc.
    if (taken) begin
      for (int unsigned i = 0; i < RB_SIZE; i++) begin
        ent_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RB_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      flush_q  <= 1'b0;
      cvalid_q <= 1'b0;
      creg_q   <= '0;
      cdata_q  <= '0;
      cidx_q   <= '0;
    end else begin
      ent_q    <= ent_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      flush_q  <= flush_d;
      cvalid_q <= cvalid_d;
      creg_q   <= creg_d;
      cdata_q  <= cdata_d;
      cidx_q   <= cidx_d;
    end
  end

  always_comb begin
    rb.CDB_data_valid = '0;
    rb.CDB_data_data  = '0;
    for (int unsigned i = 0; i < RB_SIZE; i++) begin
      rb.CDB_data_valid[i]                       = ent_q[i].busy & ent_q[i].done;
      rb.CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = ent_q[i].value;
`ifdef RB_BYPASS_EN
      if (wb_acc[i]) begin
        rb.CDB_data_valid[i]                       = 1'b1;
        rb.CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = wb_data[i];
      end
`endif
    end
  end

  assign rb.alloc_ready  = alloc_ready;
  assign rb.alloc_index  = tail_q;
  assign rb.commit_valid = cvalid_q;
  assign rb.commit_reg   = creg_q;
  assign rb.commit_data  = cdata_q;
  assign rb.commit_index = cidx_q;
  assign rb.flush        = flush_q;
  assign rb.reset_bus    = {FU_NUM{flush_q}};

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Self-checking bench for reorder_buffer. A queue-based reference model of the
//   RB (program-order queue of in-flight instructions) predicts every cycle's
//   outputs; a monitor compares them against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if rb();

  reorder_buffer u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rb      (rb)
  );

  typedef struct {
    int                   tag;
    logic [REG_INDEX-1:0] dest;
    bit                   br;
    bit                   done;
    logic [WORD_SIZE-1:0] val;
  } ment_t;

  typedef struct {
    logic                         ar;
    logic [RB_INDEX-1:0]          ai;
    logic [RB_SIZE-1:0]           cv;
    logic [WORD_SIZE*RB_SIZE-1:0] cd;
    logic                         cmv;
    logic [REG_INDEX-1:0]         creg;
    logic [WORD_SIZE-1:0]         cdata;
    logic [RB_INDEX-1:0]          cidx;
    logic                         fl;
    logic [FU_NUM-1:0]            rbus;
  } exp_t;

  // Reference model state: in-flight instructions in program order.
  ment_t                mq[$];
  int                   head_tag;
  bit                   m_flush;
  logic                 m_cv;
  logic [REG_INDEX-1:0] m_creg;
  logic [WORD_SIZE-1:0] m_cdata;
  logic [RB_INDEX-1:0]  m_cidx;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_for(input int tag, input logic [FU_NUM-1:0] v,
                                  input logic [FU_NUM*RB_INDEX-1:0] t);
    for (int f = 0; f < FU_NUM; f++)
      if (v[f] && int'(t[f*RB_INDEX +: RB_INDEX]) == tag) return f;
    return -1;
  endfunction

  function automatic logic [FU_NUM*WORD_SIZE-1:0] dl(input int f, input logic [WORD_SIZE-1:0] x);
    logic [FU_NUM*WORD_SIZE-1:0] r;
    r = '0;
    r[f*WORD_SIZE +: WORD_SIZE] = x;
    return r;
  endfunction

  function automatic logic [FU_NUM*RB_INDEX-1:0] tl(input int f, input int tag);
    logic [FU_NUM*RB_INDEX-1:0] r;
    r = '0;
    r[f*RB_INDEX +: RB_INDEX] = RB_INDEX'(tag);
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    head_tag = 0;
    m_flush  = 1'b0;
    m_cv     = 1'b0;
    m_creg   = '0;
    m_cdata  = '0;
    m_cidx   = '0;
  endtask

  task automatic idle_inputs();
    rb.alloc_req       = 1'b0;
    rb.alloc_dest_reg  = '0;
    rb.alloc_is_branch = 1'b0;
    rb.valid_bus       = '0;
    rb.data_bus        = '0;
    rb.RB_index_bus    = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".alloc_ready"},    rb.alloc_ready,    1);
    chk({tag, ".alloc_index"},    rb.alloc_index,    0);
    chk({tag, ".CDB_data_valid"}, rb.CDB_data_valid, 0);
    chk({tag, ".CDB_data_data"},  rb.CDB_data_data,  0);
    chk({tag, ".commit_valid"},   rb.commit_valid,   0);
    chk({tag, ".commit_reg"},     rb.commit_reg,     0);
    chk({tag, ".commit_data"},    rb.commit_data,    0);
    chk({tag, ".commit_index"},   rb.commit_index,   0);
    chk({tag, ".flush"},          rb.flush,          0);
    chk({tag, ".reset_bus"},      rb.reset_bus,      0);
  endtask

  // Asserts reset in mid-cycle and checks the outputs clear before any clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock of stimulus: drive inputs, predict this cycle's outputs, then
  // advance the model across the next rising edge.
  task automatic cycle(input bit req, input logic [REG_INDEX-1:0] dest, input bit br,
                       input logic [FU_NUM-1:0] v, input logic [FU_NUM*WORD_SIZE-1:0] d,
                       input logic [FU_NUM*RB_INDEX-1:0] t);
    exp_t  e;
    ment_t h;
    bit    cm;
    bit    tk;
    @(posedge clk);
    #1;
    rb.alloc_req       = req;
    rb.alloc_dest_reg  = dest;
    rb.alloc_is_branch = br;
    rb.valid_bus       = v;
    rb.data_bus        = d;
    rb.RB_index_bus    = t;

    e.ar = (mq.size() != RB_SIZE) && !m_flush;
    e.ai = RB_INDEX'((head_tag + mq.size()) % RB_SIZE);
    e.cv = '0;
    e.cd = '0;
    foreach (mq[k]) begin
      if (mq[k].done) begin
        e.cv[mq[k].tag] = 1'b1;
        e.cd[mq[k].tag*WORD_SIZE +: WORD_SIZE] = mq[k].val;
      end
    end
`ifdef RB_BYPASS_EN
    if (!m_flush) begin
      foreach (mq[k]) begin
        int f;
        f = lane_for(mq[k].tag, v, t);
        if (!mq[k].done && f >= 0) begin
          e.cv[mq[k].tag] = 1'b1;
          e.cd[mq[k].tag*WORD_SIZE +: WORD_SIZE] = d[f*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
`endif
    e.cmv   = m_cv;
    e.creg  = m_creg;
    e.cdata = m_cdata;
    e.cidx  = m_cidx;
    e.fl    = m_flush;
    e.rbus  = {FU_NUM{m_flush}};
    expq.push_back(e);

    cm = (mq.size() > 0) && mq[0].done;
    if (cm) h = mq[0];
    if (!m_flush) begin
      foreach (mq[k]) begin
        int f;
        f = lane_for(mq[k].tag, v, t);
        if (!mq[k].done && f >= 0) begin
          mq[k].done = 1'b1;
          mq[k].val  = d[f*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
    if (cm) begin
      void'(mq.pop_front());
      head_tag = (head_tag + 1) % RB_SIZE;
      m_cv     = !h.br;
      m_creg   = h.dest;
      m_cdata  = h.val;
      m_cidx   = RB_INDEX'(h.tag);
    end else begin
      m_cv    = 1'b0;
      m_creg  = '0;
      m_cdata = '0;
      m_cidx  = '0;
    end
    tk = cm && h.br && h.val[0];
    if (e.ar && req) mq.push_back('{tag: int'(e.ai), dest: dest, br: br, done: 1'b0, val: '0});
    m_flush = tk;
    if (tk) begin
      mq.delete();
      head_tag = 0;
    end
  endtask

  // Monitor: compares the DUT against each predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("alloc_ready",    rb.alloc_ready,    e.ar);
        chk("alloc_index",    rb.alloc_index,    e.ai);
        chk("CDB_data_valid", rb.CDB_data_valid, e.cv);
        chk("CDB_data_data",  rb.CDB_data_data,  e.cd);
        chk("commit_valid",   rb.commit_valid,   e.cmv);
        chk("commit_reg",     rb.commit_reg,     e.creg);
        chk("commit_data",    rb.commit_data,    e.cdata);
        chk("commit_index",   rb.commit_index,   e.cidx);
        chk("flush",          rb.flush,          e.fl);
        chk("reset_bus",      rb.reset_bus,      e.rbus);
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    #3;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Fill: tags 0..6, eighth alloc ignored.
    for (int i = 0; i < 8; i++) cycle(1'b1, REG_INDEX'(i), 1'b0, '0, '0, '0);

    // Out-of-order completion, then lane priority on tag 1.
    cycle(1'b0, '0, 1'b0, 4'b0100, dl(2, 16'h00AA), tl(2, 3));
    cycle(1'b0, '0, 1'b0, 4'b0011, dl(0, 16'h0011) | dl(1, 16'h0022), tl(0, 1) | tl(1, 1));
    cycle(1'b0, '0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("entry1_value_lane0_wins", rb.CDB_data_data[WORD_SIZE +: WORD_SIZE], 16'h0011);
    chk("entry3_done_visible",     rb.CDB_data_valid[3], 1'b1);
    chk("no_commit_head_pending",  rb.commit_valid, 1'b0);
    cycle(1'b0, '0, 1'b0, 4'b1001, dl(3, 16'h0055) | dl(0, 16'h0077), tl(3, 0) | tl(0, 2));
    repeat (6) cycle(1'b0, '0, 1'b0, '0, '0, '0);

    // Taken branch at head flushes; an alloc at that edge is dropped.
    do_reset("rst_branch");
    cycle(1'b1, 3'd2, 1'b1, '0, '0, '0);
    cycle(1'b1, 3'd5, 1'b0, '0, '0, '0);
    cycle(1'b0, '0, 1'b0, 4'b0110, dl(1, 16'h0001) | dl(2, 16'h1234), tl(1, 0) | tl(2, 1));
    cycle(1'b1, 3'd6, 1'b0, '0, '0, '0);
    repeat (3) cycle(1'b0, '0, 1'b0, '0, '0, '0);
    // Not-taken branch retires without flush.
    cycle(1'b1, 3'd3, 1'b1, '0, '0, '0);
    cycle(1'b0, '0, 1'b0, 4'b0001, dl(0, 16'h0002), tl(0, 0));
    repeat (3) cycle(1'b0, '0, 1'b0, '0, '0, '0);

    // Full RB: commit and alloc at the same edge; alloc dropped, then accepted.
    do_reset("rst_full");
    for (int i = 0; i < 7; i++) cycle(1'b1, REG_INDEX'(i), 1'b0, '0, '0, '0);
    cycle(1'b0, '0, 1'b0, 4'b0001, dl(0, 16'hBEEF), tl(0, 0));
    cycle(1'b1, 3'd7, 1'b0, '0, '0, '0);
    cycle(1'b1, 3'd4, 1'b0, '0, '0, '0);
    repeat (2) cycle(1'b0, '0, 1'b0, '0, '0, '0);

    // Async reset with four busy entries.
    do_reset("rst_mid");
    for (int i = 0; i < 4; i++) cycle(1'b1, REG_INDEX'(i), 1'b0, '0, '0, '0);
    cycle(1'b0, '0, 1'b0, 4'b0001, dl(0, 16'h00C3), tl(0, 2));
    do_reset("rst_async_4busy");

    // Randomized traffic, including NULL and stale tags.
    for (int n = 0; n < 3000; n++) begin
      logic [FU_NUM-1:0]          v;
      logic [FU_NUM*WORD_SIZE-1:0] d;
      logic [FU_NUM*RB_INDEX-1:0]  t;
      v = '0;
      d = '0;
      t = '0;
      for (int f = 0; f < FU_NUM; f++) begin
        int tag;
        v[f] = ($urandom_range(0, 2) == 0);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) tag = mq[$urandom_range(0, mq.size() - 1)].tag;
        else tag = int'($urandom_range(0, 7));
        t = t | tl(f, tag);
        d = d | dl(f, WORD_SIZE'($urandom));
      end
      if ($urandom_range(0, 499) == 0) do_reset("rst_rand");
      else cycle($urandom_range(0, 3) != 0, REG_INDEX'($urandom_range(0, 7)),
                 $urandom_range(0, 4) == 0, v, d, t);
    end

    @(posedge clk);
    #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
